at_cmd_sequencer: RTL and testbench
===================================

Name: at_cmd_sequencer

Overview:
- Drives the UART transmitter through a fixed ESP8266 bring-up script of three AT commands, then checks the module's reply on the UART receiver.
- Each command is sent byte by byte. The block then waits for "OK" or "ERROR", or for a timeout.
- A failed command is retried up to a bounded count before the block gives up. The block sits between the top level (start/status) and the UART tx/rx cores.

Parameters:
- TIMEOUT_CYCLES, 100_000_000: clock cycles to wait for a reply after the last byte of a command (1 s at 100 MHz).
- MAX_RETRY, 3: number of re-sends allowed per command after its first attempt.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; launches the script from command 0.
- tx_done_tick  in  1  UART tx finished the current byte.
- rx_done_tick  in  1  UART rx delivered a byte on rx_data.
- rx_data  in  8  received byte, valid while rx_done_tick=1.
- tx_start  out  1  one-cycle request to the UART tx.
- tx_data  out  8  byte to send; registered, stable from tx_start until the next tx_start.
- busy  out  1  high while the script is running.
- done  out  1  high when all commands have returned OK; stays high until the next start.
- error  out  1  high when a command exhausted its retries; stays high until the next start.
- cmd_idx  out  2  index of the current command (or of the failed command).
- retry_cnt  out  2  retries used on the current command.

Behaviour:
- Command ROM: combinational, 5-bit address, 23 bytes.
  - Cmd0 at addr 0-3: "AT\r\n".
  - Cmd1 at addr 4-9: "ATE0\r\n".
  - Cmd2 at addr 10-22: "AT+CWMODE=1\r\n".
  - Addr 23 holds 0x00 as the end-of-list marker.
  - A command ends at byte 0x0A.
  - Registers: addr_reg (5 b) and base_reg (5 b, first address of the current command).
- Reset (async, reset_n=0): state=IDLE, all outputs 0, addr_reg=base_reg=0, timeout counter=0, matcher cleared.
- States: IDLE, SEND, WAIT_TX, WAIT_RSP, DONE, FAIL.
- IDLE/DONE/FAIL + start:
  - addr=base=0, cmd_idx=0, retry_cnt=0.
  - done=error=0, busy=1, go to SEND.
- SEND:
  - Register tx_data=ROM[addr].
  - Assert tx_start for exactly one cycle, then go to WAIT_TX.
  - The first tx_start is visible on the cycle after the start edge.
- WAIT_TX, on tx_done_tick:
  - If ROM[addr]==0x0A: clear the timeout counter and matcher, go to WAIT_RSP.
  - Otherwise: addr++, go to SEND.
- WAIT_RSP, each cycle:
  - timeout counter increments.
  - On rx_done_tick, the matcher tracks the last two bytes.
  - 'K' directly after 'O' gives ok_hit.
  - 'R' directly after 'E','R' gives err_hit; the matcher needs 3-byte history.
- Resolution in WAIT_RSP:
  - ok_hit: retry_cnt=0, cmd_idx++, addr=base=addr+1.
    - If ROM[addr+1]==0x00: go to DONE (done=1, busy=0).
    - Otherwise: go to SEND.
  - err_hit, or counter reaching TIMEOUT_CYCLES-1:
    - If retry_cnt<MAX_RETRY: retry_cnt++, addr=base, go to SEND.
    - Otherwise: go to FAIL (error=1, busy=0). cmd_idx and retry_cnt hold their values.
- Simultaneous events:
  - ok_hit and timeout in the same cycle: OK wins.
  - err_hit and timeout in the same cycle: counts as a single failure.
- Ignored inputs:
  - start while busy.
  - tx_done_tick outside WAIT_TX.
  - rx bytes outside WAIT_RSP; echo bytes received during transmission never match.
- Outputs: tx_start and done/error are registered. done and error are never high together.
- Timeout counter width: clog2(TIMEOUT_CYCLES); it saturates and never wraps.

Test Plan:
- Happy path (TIMEOUT_CYCLES=200; rx model replies "\r\nOK\r\n" 5 cycles after each LF):
  - 23 tx_start pulses carrying bytes 41 54 0D 0A 41 54 45 30 0D 0A 41 54 2B 43 57 4D 4F 44 45 3D 31 0D 0A.
  - End state: done=1, busy=0, error=0, cmd_idx=3.
- ERROR then OK on cmd1:
  - The first reply is "ERROR\r\n".
  - "ATE0\r\n" is re-sent from 0x41, with retry_cnt=1 during the retry.
  - After OK, retry_cnt returns to 0; the run ends done=1.
- No rx at all (MAX_RETRY=3):
  - Cmd0 is sent 4 times; each resend starts TIMEOUT_CYCLES cycles after the LF tx_done_tick.
  - End state: error=1, cmd_idx=0, retry_cnt=3, busy=0.
- Simultaneous events: "OK" completes on the exact timeout cycle. Required response: the block advances to cmd1 with retry_cnt=0 (no retry).
- Reset and start handling:
  - reset_n pulled low during the 3rd byte of cmd2: all outputs 0 immediately.
  - A subsequent start re-sends from 0x41 (cmd0).
  - A start pulsed mid-run is ignored.
- Restart after FAIL: a start pulse clears error and reruns the script to done=1.

Source files
------------

// File: rtl/at_cmd_sequencer.sv
// ESP8266 bring-up sequencer: streams three AT commands to the UART transmitter,
// waits for OK/ERROR or a timeout on the UART receiver, and retries failed commands.
module at_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       tx_done_tick,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] cmd_idx,
    output logic [1:0] retry_cnt
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [1:0]       RETRY_LIM = 2'(MAX_RETRY);

    localparam logic [7:0] CH_NUL = 8'h00;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_O   = 8'h4F;
    localparam logic [7:0] CH_K   = 8'h4B;
    localparam logic [7:0] CH_E   = 8'h45;
    localparam logic [7:0] CH_R   = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_RSP,
        S_DONE,
        S_FAIL
    } state_t;

    // Command script; each command ends on LF, the list ends on NUL.
    function automatic logic [7:0] rom_byte(input logic [4:0] a);
        case (a)
            5'd0:    rom_byte = 8'h41;
            5'd1:    rom_byte = 8'h54;
            5'd2:    rom_byte = 8'h0D;
            5'd3:    rom_byte = 8'h0A;
            5'd4:    rom_byte = 8'h41;
            5'd5:    rom_byte = 8'h54;
            5'd6:    rom_byte = 8'h45;
            5'd7:    rom_byte = 8'h30;
            5'd8:    rom_byte = 8'h0D;
            5'd9:    rom_byte = 8'h0A;
            5'd10:   rom_byte = 8'h41;
            5'd11:   rom_byte = 8'h54;
            5'd12:   rom_byte = 8'h2B;
            5'd13:   rom_byte = 8'h43;
            5'd14:   rom_byte = 8'h57;
            5'd15:   rom_byte = 8'h4D;
            5'd16:   rom_byte = 8'h4F;
            5'd17:   rom_byte = 8'h44;
            5'd18:   rom_byte = 8'h45;
            5'd19:   rom_byte = 8'h3D;
            5'd20:   rom_byte = 8'h31;
            5'd21:   rom_byte = 8'h0D;
            5'd22:   rom_byte = 8'h0A;
            default: rom_byte = CH_NUL;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [4:0]       addr_q, addr_d;
    logic [4:0]       base_q, base_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       hist1_q, hist1_d;
    logic [7:0]       hist0_q, hist0_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [1:0]       cmd_idx_q, cmd_idx_d;
    logic [1:0]       retry_q, retry_d;

    logic [7:0] rom_cur;
    logic [7:0] rom_next;
    logic       ok_hit;
    logic       err_hit;
    logic       timeout;

    assign rom_cur  = rom_byte(addr_q);
    assign rom_next = rom_byte(addr_q + 5'd1);
    assign ok_hit   = rx_done_tick && (rx_data == CH_K) && (hist1_q == CH_O);
    assign err_hit  = rx_done_tick && (rx_data == CH_R) && (hist1_q == CH_R) && (hist0_q == CH_E);
    assign timeout  = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        hist1_d    = hist1_q;
        hist0_d    = hist0_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        cmd_idx_d  = cmd_idx_q;
        retry_d    = retry_q;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    addr_d    = 5'd0;
                    base_d    = 5'd0;
                    cmd_idx_d = 2'd0;
                    retry_d   = 2'd0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                tx_data_d  = rom_cur;
                tx_start_d = 1'b1;
                state_d    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_done_tick) begin
                    if (rom_cur == CH_LF) begin
                        cnt_d   = '0;
                        hist1_d = CH_NUL;
                        hist0_d = CH_NUL;
                        state_d = S_WAIT_RSP;
                    end else begin
                        addr_d  = addr_q + 5'd1;
                        state_d = S_SEND;
                    end
                end
            end
            S_WAIT_RSP: begin
                if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (rx_done_tick) begin
                    hist0_d = hist1_q;
                    hist1_d = rx_data;
                end
                // OK outranks a timeout landing on the same cycle.
                if (ok_hit) begin
                    retry_d   = 2'd0;
                    cmd_idx_d = cmd_idx_q + 2'd1;
                    addr_d    = addr_q + 5'd1;
                    base_d    = addr_q + 5'd1;
                    if (rom_next == CH_NUL) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SEND;
                    end
                end else if (err_hit || timeout) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 2'd1;
                        addr_d  = base_q;
                        state_d = S_SEND;
                    end else begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FAIL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= 5'd0;
            base_q     <= 5'd0;
            cnt_q      <= '0;
            hist1_q    <= CH_NUL;
            hist0_q    <= CH_NUL;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cmd_idx_q  <= 2'd0;
            retry_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            hist1_q    <= hist1_d;
            hist0_q    <= hist0_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cmd_idx_q  <= cmd_idx_d;
            retry_q    <= retry_d;
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cmd_idx   = cmd_idx_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_at_cmd_sequencer.sv
// Bench for at_cmd_sequencer: UART tx/rx models driven by a reply script, checked
// against a command-level model of the bring-up script.
module tb_at_cmd_sequencer;

    localparam int T    = 200;
    localparam int MAXR = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic       tx_done_tick = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] cmd_idx;
    logic [1:0] retry_cnt;

    at_cmd_sequencer #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .tx_done_tick(tx_done_tick), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .done(done),
        .error(error), .cmd_idx(cmd_idx), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reply script: one entry per command attempt; flags bit0 = leading CRLF, bit1 = trailing CRLF.
    string sb[$];
    int    sp[$];
    int    sd[$];
    int    rs_ptr = 0;

    // Transmit log captured from the DUT.
    logic [7:0] lg_b[$];
    logic [1:0] lg_cmd[$];
    logic [1:0] lg_rty[$];
    int         lg_gap[$];

    // Model expectations.
    logic [7:0] exp_b[$];
    logic [1:0] exp_cmd[$];
    logic [1:0] exp_rty[$];
    bit         exp_done, exp_err;
    int         exp_cidx, exp_rfin;

    logic [7:0] rx_pend[$];
    int         rx_wait = 0;
    bit         noise_en = 0;
    int         cyc = 0;
    int         last_lf = 0;
    int         txd_cnt = -1;
    logic [7:0] cur_byte = 8'h00;

    string cmd_txt[3] = '{"AT", "ATE0", "AT+CWMODE=1"};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int reply_len(input int k);
        return sb[k].len() + ((sp[k] & 1) ? 2 : 0) + ((sp[k] & 2) ? 2 : 0);
    endfunction

    function automatic logic [7:0] reply_byte(input int k, input int i);
        int off = (sp[k] & 1) ? 2 : 0;
        int n   = sb[k].len();
        if (off == 2 && i == 0) return 8'h0D;
        if (off == 2 && i == 1) return 8'h0A;
        if (i - off < n) return sb[k][i - off];
        return (i - off == n) ? 8'h0D : 8'h0A;
    endfunction

    // An attempt succeeds when "OK" is fully received within T cycles of the LF.
    function automatic bit reply_ok(input int k);
        for (int i = 0; i + 1 < reply_len(k); i++)
            if (reply_byte(k, i) == 8'h4F && reply_byte(k, i + 1) == 8'h4B && sd[k] + i + 1 <= T)
                return 1'b1;
        return 1'b0;
    endfunction

    // UART model: tx completes 3-6 cycles after tx_start; rx replies after each LF.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            tx_done_tick = 1'b0;
            rx_done_tick = 1'b0;
            if (!reset_n) begin
                txd_cnt = -1;
                rx_pend.delete();
            end else begin
                if (rx_pend.size() > 0) begin
                    if (rx_wait > 0) rx_wait--;
                    else begin
                        rx_data      = rx_pend.pop_front();
                        rx_done_tick = 1'b1;
                    end
                end
                if (txd_cnt == 0) begin
                    tx_done_tick = 1'b1;
                    txd_cnt      = -1;
                    if (cur_byte == 8'h0A) begin
                        last_lf = cyc;
                        if (rs_ptr < sb.size()) begin
                            for (int i = 0; i < reply_len(rs_ptr); i++)
                                rx_pend.push_back(reply_byte(rs_ptr, i));
                            rx_wait = sd[rs_ptr] - 1;
                        end
                        rs_ptr++;
                    end else if (noise_en) begin
                        rx_pend.push_back(8'h4F);
                        rx_pend.push_back(8'h4B);
                    end
                end else if (txd_cnt > 0) begin
                    txd_cnt--;
                end
                if (tx_start === 1'b1) begin
                    cur_byte = tx_data;
                    lg_b.push_back(tx_data);
                    lg_cmd.push_back(cmd_idx);
                    lg_rty.push_back(retry_cnt);
                    lg_gap.push_back(cyc - last_lf);
                    txd_cnt = int'($urandom_range(2, 5));
                end
            end
        end
    end

    task automatic clear_script();
        sb.delete(); sp.delete(); sd.delete();
    endtask

    task automatic add_reply(input string body, input int flags, input int dly);
        sb.push_back(body); sp.push_back(flags); sd.push_back(dly);
    endtask

    // Command-level model: walk the attempts, consuming one reply per attempt.
    task automatic launch();
        int c = 0;
        int r = 0;
        int k = 0;
        bit ok;
        rs_ptr = 0;
        lg_b.delete(); lg_cmd.delete(); lg_rty.delete(); lg_gap.delete();
        exp_b.delete(); exp_cmd.delete(); exp_rty.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        while (c < 3) begin
            for (int i = 0; i < cmd_txt[c].len() + 2; i++) begin
                exp_b.push_back(i < cmd_txt[c].len() ? cmd_txt[c][i] : (i == cmd_txt[c].len() ? 8'h0D : 8'h0A));
                exp_cmd.push_back(2'(c));
                exp_rty.push_back(2'(r));
            end
            ok = (k < sb.size()) ? reply_ok(k) : 1'b0;
            k++;
            if (ok) begin
                c++;
                r = 0;
            end else if (r < MAXR) begin
                r++;
            end else begin
                exp_err = 1'b1;
                break;
            end
        end
        exp_done = !exp_err;
        exp_cidx = c;
        exp_rfin = r;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_cmd_idx"}, 32'(cmd_idx), 32'd0);
        check({tag, "_retry"}, 32'(retry_cnt), 32'd0);
    endtask

    task automatic start_script(input string tag);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_busy_up"}, 32'(busy), 32'd1);
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_err_clr"}, 32'(error), 32'd0);
        check({tag, "_cmd0"}, 32'(cmd_idx), 32'd0);
        check({tag, "_txs_early"}, 32'(tx_start), 32'd0);
        @(negedge clk);
        check({tag, "_txs_first"}, 32'(tx_start), 32'd1);
        check({tag, "_txd_first"}, 32'(tx_data), 32'h41);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finished"}, 32'(busy === 1'b0), 32'd1);
    endtask

    task automatic check_run(input string tag);
        int n = (lg_b.size() < exp_b.size()) ? lg_b.size() : exp_b.size();
        check({tag, "_ntx"}, 32'(lg_b.size()), 32'(exp_b.size()));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(lg_b[i]), 32'(exp_b[i]));
            check($sformatf("%s_cmd%0d", tag, i), 32'(lg_cmd[i]), 32'(exp_cmd[i]));
            check($sformatf("%s_rty%0d", tag, i), 32'(lg_rty[i]), 32'(exp_rty[i]));
        end
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cmd_idx"}, 32'(cmd_idx), 32'(exp_cidx));
        check({tag, "_retry"}, 32'(retry_cnt), 32'(exp_rfin));
    endtask

    initial begin
        int n;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Happy path with a start pulse mid-run that must be ignored.
        clear_script();
        repeat (3) add_reply("OK", 3, 5);
        launch();
        start_script("happy");
        repeat (40) @(negedge clk);
        pulse_start();
        wait_idle("happy", 3000);
        check_run("happy");
        repeat (30) @(negedge clk);

        // ERROR then OK on cmd1.
        clear_script();
        add_reply("OK", 3, int'($urandom_range(3, 20)));
        add_reply("ERROR", 2, int'($urandom_range(3, 20)));
        add_reply("OK", 3, int'($urandom_range(3, 20)));
        add_reply("OK", 3, int'($urandom_range(3, 20)));
        launch();
        start_script("errok");
        wait_idle("errok", 3000);
        check_run("errok");
        repeat (30) @(negedge clk);

        // No reply at all: cmd0 sent 1+MAXR times then FAIL.
        clear_script();
        launch();
        start_script("norx");
        wait_idle("norx", 3000);
        check_run("norx");
        // Timeout resolves T edges after the LF edge; the resend's tx_start registers one edge later.
        for (int i = 4; i < 16 && i < lg_gap.size(); i += 4)
            check($sformatf("norx_gap%0d", i), 32'(lg_gap[i]), 32'(T + 2));
        repeat (30) @(negedge clk);

        // Restart after FAIL, with OK-shaped echo noise during transmission.
        noise_en = 1'b1;
        clear_script();
        repeat (3) add_reply("OK", 3, int'($urandom_range(3, 30)));
        launch();
        start_script("restart");
        wait_idle("restart", 3000);
        check_run("restart");
        noise_en = 1'b0;
        repeat (30) @(negedge clk);

        // OK completing on the timeout cycle, then ERR completing on the timeout cycle.
        clear_script();
        add_reply("OK", 0, T - 1);
        add_reply("ERR", 0, T - 2);
        add_reply("OK", 3, 5);
        add_reply("OK", 3, 5);
        launch();
        start_script("simul");
        wait_idle("simul", 4000);
        check_run("simul");
        repeat (30) @(negedge clk);

        // Reset during the third byte of cmd2, then a clean rerun.
        clear_script();
        repeat (3) add_reply("OK", 3, 5);
        launch();
        start_script("rmid");
        n = 0;
        while (lg_b.size() < 13 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("rmid_reached", 32'(lg_b.size() >= 13), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_zero("rmid_async");
        @(negedge clk);
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(negedge clk);
        clear_script();
        repeat (3) add_reply("OK", 3, int'($urandom_range(3, 20)));
        launch();
        start_script("rerun");
        repeat (20) @(negedge clk);
        pulse_start();
        wait_idle("rerun", 3000);
        check_run("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
